// File: rtl/ibex_ex_multdiv_seq_if.sv
// Bundle of issue, multdiv-control, writeback and status signals around the M-extension sequencer.
// The master modport is the environment side (ID stage, multdiv unit, writeback); slave is the sequencer.
interface ibex_ex_multdiv_seq_if #(
  parameter int CntW = 6
);
  // Handshakes: a transfer happens on a rising clock edge where valid and ready are both 1.
  // valid never depends on ready; ready may depend combinationally on valid-side state.
  // Once raised, wb_valid stays high with wb_rd/wb_data stable until wb_ready or flush.
  logic            issue_valid;
  logic            issue_ready;
  logic [1:0]      issue_op;
  logic [1:0]      issue_signed;
  logic [4:0]      issue_rd;
  logic            flush;
  logic            mult_en;
  logic            div_en;
  logic [1:0]      multdiv_operator;
  logic [1:0]      multdiv_signed_mode;
  logic            multdiv_valid;
  logic [31:0]     multdiv_result;
  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [31:0]     wb_data;
  logic            busy;
  logic [CntW-1:0] run_cycles;
  logic            err;
  logic [1:0]      dbg_state;

  modport master (
    output issue_valid, issue_op, issue_signed, issue_rd, flush,
    output multdiv_valid, multdiv_result, wb_ready,
    input  issue_ready, mult_en, div_en, multdiv_operator, multdiv_signed_mode,
    input  wb_valid, wb_rd, wb_data, busy, run_cycles, err, dbg_state
  );

  modport slave (
    input  issue_valid, issue_op, issue_signed, issue_rd, flush,
    input  multdiv_valid, multdiv_result, wb_ready,
    output issue_ready, mult_en, div_en, multdiv_operator, multdiv_signed_mode,
    output wb_valid, wb_rd, wb_data, busy, run_cycles, err, dbg_state
  );
endinterface

// File: rtl/ibex_ex_multdiv_seq.sv
// IDLE/RUN/WB sequencer driving the multi-cycle MULT/DIV unit and buffering its result for writeback.
// Define IBEX_EX_SEQ_WATCHDOG_EN to abort RUN after MaxLatency cycles with a one-cycle err pulse.
module ibex_ex_multdiv_seq #(
  parameter int MaxLatency = 37,
  parameter int CntW       = 6
) (
  input logic                 clk_i,
  input logic                 rst_i,
  ibex_ex_multdiv_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_e;

  localparam logic [CntW-1:0] CntMax = '1;

  if (MaxLatency < 2 || (1 << CntW) <= MaxLatency) begin : g_bad_params
    $error("ibex_ex_multdiv_seq: need MaxLatency >= 2 and 2**CntW > MaxLatency");
  end

  state_e          state_q, state_d;
  logic [1:0]      op_q;
  logic [1:0]      sgn_q;
  logic [4:0]      rd_q;
  logic [31:0]     data_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_inc;
  logic [CntW-1:0] run_cycles_q, run_cycles_d;
  logic            in_run;
  logic            accept;
  logic            capture;
  logic            timeout;

  assign in_run          = (state_q == RUN);
  // Ready while retiring lets the next op issue in the same cycle the result leaves.
  assign bus.issue_ready = ~bus.flush & ((state_q == IDLE) | ((state_q == WB) & bus.wb_ready));
  assign accept          = bus.issue_valid & bus.issue_ready;
  assign capture         = in_run & bus.multdiv_valid & ~bus.flush;
  assign cnt_inc         = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

`ifdef IBEX_EX_SEQ_WATCHDOG_EN
  localparam logic [CntW-1:0] LastCnt = CntW'(MaxLatency - 1);
  localparam logic [CntW-1:0] LatCnt  = CntW'(MaxLatency);

  logic err_q;

  // A valid in the final allowed cycle wins over the abort.
  assign timeout = in_run & ~bus.multdiv_valid & ~bus.flush & (cnt_q == LastCnt);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
    end
  end

  assign bus.err = err_q;
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (capture)      state_d = WB;
        else if (timeout) state_d = IDLE;
      end
      WB:   if (bus.wb_ready) state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_comb begin
    run_cycles_d = run_cycles_q;
    if (capture) run_cycles_d = cnt_inc;
`ifdef IBEX_EX_SEQ_WATCHDOG_EN
    if (timeout) run_cycles_d = LatCnt;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      op_q         <= 2'b00;
      sgn_q        <= 2'b00;
      rd_q         <= 5'd0;
      data_q       <= 32'd0;
      cnt_q        <= '0;
      run_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      run_cycles_q <= run_cycles_d;
      if (accept) begin
        op_q  <= bus.issue_op;
        sgn_q <= bus.issue_signed;
        rd_q  <= bus.issue_rd;
        cnt_q <= '0;
      end else if (in_run) begin
        cnt_q <= cnt_inc;
      end
      if (capture) data_q <= bus.multdiv_result;
    end
  end

  // Enables decode from registered state, so they rise on the first RUN cycle.
  assign bus.mult_en             = in_run & ~op_q[1];
  assign bus.div_en              = in_run & op_q[1];
  assign bus.multdiv_operator    = op_q;
  assign bus.multdiv_signed_mode = sgn_q;
  assign bus.wb_valid            = (state_q == WB);
  assign bus.wb_rd               = rd_q;
  assign bus.wb_data             = data_q;
  assign bus.busy                = (state_q != IDLE);
  assign bus.run_cycles          = run_cycles_q;
  assign bus.dbg_state           = state_q;

endmodule

// File: tb/tb_ibex_ex_multdiv_seq.sv
// Self-checking bench for ibex_ex_multdiv_seq: the bench plays the multdiv unit and writeback
// consumer, and predicts enable duration, result, run_cycles and watchdog aborts per operation.
module tb_ibex_ex_multdiv_seq;

`ifdef IBEX_EX_SEQ_WATCHDOG_EN
  localparam int ML = 8;
  localparam bit WD = 1'b1;
`else
  localparam int ML = 37;
  localparam bit WD = 1'b0;
`endif
  localparam int CW = 6;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  bit   last_to;
  logic [31:0] exp_q[$];

  ibex_ex_multdiv_seq_if #(.CntW(CW)) bus ();

  ibex_ex_multdiv_seq #(.MaxLatency(ML), .CntW(CW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks; all start and end at a falling edge
  task automatic do_issue(input logic [1:0] op, input logic [1:0] sgn, input logic [4:0] rd);
    bus.issue_valid  = 1'b1;
    bus.issue_op     = op;
    bus.issue_signed = sgn;
    bus.issue_rd     = rd;
    #1 check("issue_ready", bus.issue_ready, 1);
    @(negedge clk);
    bus.issue_valid  = 1'b0;
    bus.issue_op     = 2'($urandom_range(0, 3));
    bus.issue_signed = 2'($urandom_range(0, 3));
  endtask

  // Acts as the multdiv unit: raise valid on the lat-th enabled cycle.
  task automatic do_run(input logic [1:0] op, input logic [1:0] sgn, input int lat,
                        input logic [31:0] res);
    int cyc;
    bit bad;
    bit to;
    cyc = 0;
    bad = 1'b0;
    to  = WD && (lat > ML);
    while ((bus.mult_en || bus.div_en) && cyc < 100) begin
      if (bus.mult_en !== (op < 2) || bus.div_en !== (op >= 2) ||
          bus.multdiv_operator !== op || bus.multdiv_signed_mode !== sgn ||
          bus.wb_valid !== 1'b0 || bus.busy !== 1'b1 || bus.issue_ready !== 1'b0) bad = 1'b1;
      cyc++;
      if (cyc == lat) begin
        bus.multdiv_valid  = 1'b1;
        bus.multdiv_result = res;
        exp_q.push_back(res);
      end
      @(negedge clk);
      bus.multdiv_valid  = 1'b0;
      bus.multdiv_result = $urandom;
    end
    check("run_ctrl", bad, 0);
    check("en_cycles", cyc, to ? ML : lat);
    last_to = to;
    if (to) begin
      check("wd_err", bus.err, 1);
      check("wd_no_wb", bus.wb_valid, 0);
      check("wd_idle", bus.busy, 0);
      check("wd_run_cycles", bus.run_cycles, ML);
      @(negedge clk);
      check("wd_err_pulse", bus.err, 0);
    end
  endtask

  task automatic do_wb(input logic [4:0] rd, input int stall, input int lat);
    logic [31:0] exp;
    bit bad;
    if (last_to) return;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("wb_valid", bus.wb_valid, 1);
    check("wb_data", bus.wb_data, exp);
    check("wb_rd", bus.wb_rd, rd);
    check("run_cycles", bus.run_cycles, lat);
    check("err_quiet", bus.err, 0);
    check("wb_enables", {bus.mult_en, bus.div_en}, 0);
    bad = 1'b0;
    for (int s = 1; s < stall; s++) begin
      @(negedge clk);
      if (bus.wb_data !== exp || bus.wb_rd !== rd || bus.wb_valid !== 1'b1 ||
          bus.issue_ready !== 1'b0 || bus.busy !== 1'b1) bad = 1'b1;
    end
    check("wb_hold", bad, 0);
    bus.wb_ready = 1'b1;
    #1 check("retire_ready", bus.issue_ready, 1);
    @(negedge clk);
    bus.wb_ready = 1'b0;
    check("retired_valid", bus.wb_valid, 0);
    check("retired_busy", bus.busy, 0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [1:0] sgn, input logic [4:0] rd,
                        input int lat, input logic [31:0] res, input int stall);
    do_issue(op, sgn, rd);
    do_run(op, sgn, lat, res);
    do_wb(rd, stall, lat);
  endtask

  initial begin
    logic [31:0] r;
    n_checks = 0;
    n_pass   = 0;
    last_to  = 1'b0;
    rst = 1'b1;
    bus.issue_valid = 0; bus.issue_op = 0; bus.issue_signed = 0; bus.issue_rd = 0;
    bus.flush = 0; bus.multdiv_valid = 0; bus.multdiv_result = 0; bus.wb_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.issue_ready, 1);
    check("rst_outs", {bus.mult_en, bus.div_en, bus.multdiv_operator, bus.multdiv_signed_mode,
                       bus.wb_valid, bus.busy, bus.err, bus.wb_rd}, 0);
    check("rst_data", bus.wb_data, 0);
    check("rst_run_cycles", bus.run_cycles, 0);
    rst = 1'b0;
    @(negedge clk);

    // MULL, valid 3 cycles after enable
    run_op(2'd0, 2'b00, 5'd5, 3, 32'h0000_0F0F, 0);
    // signed DIV, 34 cycles, writeback stalled 5 cycles
    run_op(2'd2, 2'b11, 5'd9, 34, $urandom, 5);
    // valid exactly in the last cycle the watchdog allows
    run_op(2'd1, 2'b01, 5'd17, ML, $urandom, 1);
    // valid never comes inside the limit
    run_op(2'd3, 2'b10, 5'd20, ML + 8, $urandom, 0);

    // back-to-back: retire MULH and accept REM in the same cycle
    do_issue(2'd1, 2'b01, 5'd7);
    do_run(2'd1, 2'b01, 2, 32'h1234_5678);
    r = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("b2b_wb_data", bus.wb_data, r);
    bus.wb_ready = 1'b1; bus.issue_valid = 1'b1; bus.issue_op = 2'd3;
    bus.issue_signed = 2'b10; bus.issue_rd = 5'd12;
    #1 check("b2b_ready", bus.issue_ready, 1);
    @(negedge clk);
    bus.wb_ready = 1'b0; bus.issue_valid = 1'b0;
    check("b2b_div_en", bus.div_en, 1);
    check("b2b_busy", bus.busy, 1);
    check("b2b_wb_valid", bus.wb_valid, 0);
    do_run(2'd3, 2'b10, 4, 32'hCAFE_0001);
    do_wb(5'd12, 0, 4);

    // flush in RUN together with multdiv valid
    do_issue(2'd2, 2'b00, 5'd3);
    bus.flush = 1'b1; bus.multdiv_valid = 1'b1; bus.multdiv_result = 32'hBAD0_BAD0;
    #1 check("flush_ready", bus.issue_ready, 0);
    @(negedge clk);
    bus.flush = 1'b0; bus.multdiv_valid = 1'b0;
    check("flush_idle", {bus.busy, bus.wb_valid, bus.mult_en, bus.div_en}, 0);
    @(negedge clk);
    check("flush_no_wb", bus.wb_valid, 0);

    // flush together with issue in IDLE accepts nothing
    bus.flush = 1'b1; bus.issue_valid = 1'b1; bus.issue_op = 2'd0;
    #1 check("flush_issue_ready", bus.issue_ready, 0);
    @(negedge clk);
    bus.flush = 1'b0; bus.issue_valid = 1'b0;
    check("flush_issue_idle", {bus.busy, bus.mult_en, bus.div_en}, 0);

    // flush while a result waits in WB
    do_issue(2'd0, 2'b00, 5'd4);
    do_run(2'd0, 2'b00, 1, 32'h0000_0001);
    void'(exp_q.pop_front());
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_wb_drop", {bus.busy, bus.wb_valid}, 0);

    // multdiv valid while IDLE is ignored
    bus.multdiv_valid = 1'b1; bus.multdiv_result = 32'h5555_AAAA;
    @(negedge clk);
    bus.multdiv_valid = 1'b0;
    check("stray_valid", {bus.busy, bus.wb_valid}, 0);

    // reset in the middle of RUN
    do_issue(2'd3, 2'b11, 5'd30);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst_mid_outs", {bus.mult_en, bus.div_en, bus.multdiv_operator,
                              bus.multdiv_signed_mode, bus.wb_valid, bus.busy, bus.err}, 0);
    check("rst_mid_cycles", bus.run_cycles, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_mid_ready", bus.issue_ready, 1);
    @(negedge clk);

    // randomized operations
    for (int i = 0; i < 24; i++) begin
      run_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
             $urandom_range(1, 40), $urandom, $urandom_range(0, 3));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
